// File: rtl/bus_arbiter.sv
// Four-requester round-robin bus arbiter with registered one-hot grant and one dead cycle per release.
// Optional forced revocation of long holds is compiled in with BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [3:0] done,
  output logic [3:0] grant,
  output logic [1:0] bus_sel,
  output logic       bus_busy,
  output logic       timeout
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("bus_arbiter: MAX_HOLD must be in 2..255");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state, state_nxt;
  logic [3:0] grant_nxt;
  logic [1:0] sel_nxt, last_owner, last_nxt, rr_idx;
  logic       rr_found, owner_hold, hold_expired;

  // bus_sel is the owner index whenever the FSM is BUSY
  assign owner_hold = req[bus_sel] & ~done[bus_sel];

`ifdef BUS_ARBITER_TIMEOUT_EN
  logic [7:0] hold_cnt;

  assign hold_expired = (hold_cnt == 8'(MAX_HOLD - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_cnt <= 8'd0;
      timeout  <= 1'b0;
    end else begin
      timeout  <= (state == BUSY) && owner_hold && hold_expired;
      hold_cnt <= (state == BUSY) ? hold_cnt + 8'd1 : 8'd0;
    end
  end
`else
  assign hold_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  // Search upward from the slot after the last owner; i = 4 lands back on last_owner itself
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      if (!rr_found && req[last_owner + 2'(i)]) begin
        rr_found = 1'b1;
        rr_idx   = last_owner + 2'(i);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    sel_nxt   = bus_sel;
    last_nxt  = last_owner;
    case (state)
      IDLE: begin
        grant_nxt = 4'b0000;
        if (rr_found) begin
          grant_nxt = 4'b0001 << rr_idx;
          sel_nxt   = rr_idx;
          last_nxt  = rr_idx;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (!owner_hold || hold_expired) begin
          grant_nxt = 4'b0000;
          state_nxt = IDLE;
        end
      end
      default: begin
        grant_nxt = 4'b0000;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 4'b0000;
      bus_sel    <= 2'd0;
      bus_busy   <= 1'b0;
      last_owner <= 2'd3;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      bus_sel    <= sel_nxt;
      bus_busy   <= |grant_nxt;
      last_owner <= last_nxt;
    end
  end

endmodule
